// File: rtl/counter_arbiter_pkg.sv
// Shared sizing for the counter arbiter: channel count, count width,
// round-robin pointer width and the per-channel count type.
package counter_arbiter_pkg;

  localparam int NCH   = 4;
  localparam int W     = 4;
  localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;

  typedef logic [W-1:0] cnt_t;

endpackage

// File: rtl/counter_arbiter_rr_arbiter.sv
// Round-robin picker: the first eligible channel at or above ptr_i wins,
// searching upward and wrapping from NCH-1 back to channel 0.
module rr_arbiter #(
  parameter int NCH = 4,
  parameter int PW  = 2
) (
  input  logic [NCH-1:0] eligible_i,
  input  logic [PW-1:0]  ptr_i,
  output logic [NCH-1:0] grant_o
);

  logic found;
  int   idx;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = 0;
    for (int off = 0; off < NCH; off++) begin
      // ptr_i is always below NCH, so one subtraction is enough to wrap.
      idx = int'(ptr_i) + off;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && eligible_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_arbiter.sv
// NCH channels share one incrementer. A round-robin grant picks one requester
// per cycle; its count advances (wrapping after io_limit) at the next edge.
module counter_arbiter #(
  parameter int NCH = counter_arbiter_pkg::NCH,
  parameter int W   = counter_arbiter_pkg::W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_en,
  input  logic [NCH-1:0]   io_req,
  input  logic [NCH-1:0]   io_clr,
  input  logic [W-1:0]     io_limit,
  output logic [NCH-1:0]   io_grant,
  output logic [NCH*W-1:0] io_cnt,
  output logic [NCH-1:0]   io_wrap,
  output logic             io_busy
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]        elig;
  logic [NCH-1:0][W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [NCH-1:0]        wrap_q, wrap_d;

  // A channel being cleared cannot also be granted in the same cycle.
  assign elig    = (reset || !io_en) ? '0 : (io_req & ~io_clr);
  assign io_busy = |elig;

  rr_arbiter #(
    .NCH (NCH),
    .PW  (PW)
  ) u_rr (
    .eligible_i (elig),
    .ptr_i      (ptr_q),
    .grant_o    (io_grant)
  );

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = '0;
    ptr_d  = ptr_q;
    for (int k = 0; k < NCH; k++) begin
      if (io_clr[k]) begin
        cnt_d[k] = '0;
      end else if (io_grant[k]) begin
        // >= rather than == so a count stranded above a lowered limit wraps.
        if (cnt_q[k] >= io_limit) begin
          cnt_d[k]  = '0;
          wrap_d[k] = 1'b1;
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
        ptr_d = (k == NCH - 1) ? '0 : PW'(k + 1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      ptr_q  <= '0;
      wrap_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      ptr_q  <= ptr_d;
      wrap_q <= wrap_d;
    end
  end

  assign io_cnt  = cnt_q;
  assign io_wrap = wrap_q;

endmodule
